seq_div: RTL and testbench

//   Multi-cycle radix-2 restoring unsigned divider with valid/ready handshakes
//   on both sides. One quotient bit per clock.

---
 rtl/seq_div.sv | 200 ++++++++++++++++++++
 tb/tb_seq_div.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// -----------------------------------------------------------------------------
// seq_div
//
// Multi-cycle radix-2 restoring unsigned divider. It resolves one quotient bit
// per clock, and both sides use valid/ready handshakes. In the RMS datapath it
// sits between the mean-square accumulator and the square-root stage. It
// replaces the older combinational divider, adding a register boundary,
// backpressure and divide-by-zero flagging.
//
// Parameters
//   NUMER_W : dividend / quotient width (>= 2)
//   DENOM_W : divisor / remainder width (>= 1, <= NUMER_W)
//
// Ports
//   clk         : single clock, all state changes on the rising edge
//   rst         : synchronous, active-high reset; aborts any operation in flight
//   in_valid    : numer/denom are valid
//   in_ready    : divider can accept an operand pair (only while idle)
//   numer       : unsigned dividend, captured on the accept edge
//   denom       : unsigned divisor, captured on the accept edge
//   out_valid   : quot/rem/div_by_zero hold a result
//   out_ready   : downstream accepts the result
//   quot        : quotient, floor(numer/denom); all ones on divide-by-zero
//   rem         : remainder, numer mod denom; numer's low bits on divide-by-zero
//   div_by_zero : result came from a zero divisor
//
// Timing
//   A non-zero divisor spends NUMER_W cycles in CALC. out_valid rises after
//   the NUMER_W-th edge that follows the accept edge. A zero divisor skips
//   CALC, so its result is valid right after the accept edge. With out_ready
//   tied high, the divider completes one operation every NUMER_W+2 cycles.
// -----------------------------------------------------------------------------
module seq_div #(
  parameter int NUMER_W = 8,
  parameter int DENOM_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUMER_W-1:0] numer,
  input  logic [DENOM_W-1:0] denom,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUMER_W-1:0] quot,
  output logic [DENOM_W-1:0] rem,
  output logic               div_by_zero
);

  // Iteration counter sized to hold NUMER_W-1, the value loaded at accept.
  localparam int CNT_W = (NUMER_W > 1) ? $clog2(NUMER_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUMER_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Operand and iteration state.
  logic [DENOM_W-1:0] denom_q;
  logic [NUMER_W-1:0] work_q;
  logic [DENOM_W-1:0] prem_q;
  logic [CNT_W-1:0]   cnt_q;

  // Per-iteration combinational results.
  logic [DENOM_W:0]   trial;
  logic               qbit;
  logic [DENOM_W-1:0] prem_next;
  logic [NUMER_W-1:0] work_next;
  logic               last_iter;

  logic accept;
  logic handshake;
  logic denom_zero;

  assign accept     = in_valid && in_ready;
  assign handshake  = out_valid && out_ready;
  assign denom_zero = (denom == '0);
  assign last_iter  = (cnt_q == '0);

  // One restoring step.
  // work_q starts as the dividend. Each step shifts one dividend bit out of
  // the top and one quotient bit in at the bottom. After NUMER_W steps,
  // work_q holds exactly the quotient.
  //
  // The partial remainder is always < denom, so its top bit would always be
  // zero. Only DENOM_W bits are stored. The trial value carries the extra
  // bit, so the compare against denom never overflows. When qbit is set,
  // trial - denom < denom, so the subtraction is exact in DENOM_W bits.
  always_comb begin
    trial     = {prem_q, work_q[NUMER_W-1]};
    qbit      = (trial >= {1'b0, denom_q});
    prem_next = trial[DENOM_W-1:0];
    if (qbit) begin
      prem_next = trial[DENOM_W-1:0] - denom_q;
    end
    work_next = {work_q[NUMER_W-2:0], qbit};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // A zero divisor bypasses CALC entirely. Its result is fixed at accept
  // time, so there is nothing to iterate.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = denom_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (handshake) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake outputs are registered copies of the next-state decode.
  // They therefore change on the same edge as the state, without a
  // combinational path from the state register to the ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
    end
  end

  // Datapath.
  // quot/rem are written only when a result is produced: at accept for a
  // zero divisor, or on the final CALC step. They keep the last result
  // through IDLE and the next CALC phase, and stay stable in DONE under
  // backpressure. div_by_zero changes only at accept time.
  always_ff @(posedge clk) begin
    if (rst) begin
      denom_q     <= '0;
      work_q      <= '0;
      prem_q      <= '0;
      cnt_q       <= '0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (denom_zero) begin
              quot        <= '1;
              rem         <= numer[DENOM_W-1:0];
              div_by_zero <= 1'b1;
            end else begin
              denom_q     <= denom;
              work_q      <= numer;
              prem_q      <= '0;
              cnt_q       <= CNT_LAST;
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          work_q <= work_next;
          prem_q <= prem_next;
          if (last_iter) begin
            quot <= work_next;
            rem  <= prem_next;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// -----------------------------------------------------------------------------
// tb_seq_div
//
// Bench for seq_div. Two instances share one clock and reset:
//   dut_n : NUMER_W=8,  DENOM_W=4  (directed scenarios)
//   dut_w : NUMER_W=16, DENOM_W=8  (corner values plus a random sweep)
// When an operand pair is accepted, its expected result (from the / and %
// operators, or the divide-by-zero encoding) goes into a per-instance queue.
// The expected result is popped when the DUT presents its output.
// -----------------------------------------------------------------------------
module tb_seq_div;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Narrow instance signals.
  logic       n_in_valid;
  logic       n_in_ready;
  logic [7:0] n_numer;
  logic [3:0] n_denom;
  logic       n_out_valid;
  logic       n_out_ready;
  logic [7:0] n_quot;
  logic [3:0] n_rem;
  logic       n_dbz;

  // Wide instance signals.
  logic        w_in_valid;
  logic        w_in_ready;
  logic [15:0] w_numer;
  logic [7:0]  w_denom;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [15:0] w_quot;
  logic [7:0]  w_rem;
  logic        w_dbz;

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
  } result_t;

  result_t sb_n[$];
  result_t sb_w[$];

  int checks   = 0;
  int failures = 0;

  seq_div #(.NUMER_W(8), .DENOM_W(4)) dut_n (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (n_in_valid),
    .in_ready    (n_in_ready),
    .numer       (n_numer),
    .denom       (n_denom),
    .out_valid   (n_out_valid),
    .out_ready   (n_out_ready),
    .quot        (n_quot),
    .rem         (n_rem),
    .div_by_zero (n_dbz)
  );

  seq_div #(.NUMER_W(16), .DENOM_W(8)) dut_w (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (w_in_valid),
    .in_ready    (w_in_ready),
    .numer       (w_numer),
    .denom       (w_denom),
    .out_valid   (w_out_valid),
    .out_ready   (w_out_ready),
    .quot        (w_quot),
    .rem         (w_rem),
    .div_by_zero (w_dbz)
  );

  // Waits for in_ready, presents one operand pair for exactly one edge, then
  // scrambles the inputs. The DUT must rely only on the values it latched.
  task automatic applyStimulus(input logic [7:0] a, input logic [3:0] b);
    result_t e;
    int guard = 0;
    while (!n_in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!n_in_ready) begin
      checks++; failures++;
      $display("[TB] FAIL accept_timeout_n in_ready=%0b required=1", n_in_ready);
    end
    n_in_valid = 1'b1;
    n_numer    = a;
    n_denom    = b;
    @(posedge clk); #1;
    n_in_valid = 1'b0;
    n_numer    = 8'($urandom);
    n_denom    = 4'($urandom);
    e.q = (b == 4'd0) ? 16'h00FF : 16'(a / b);
    e.r = (b == 4'd0) ? {4'd0, a[3:0]} : 8'(a % b);
    e.z = (b == 4'd0);
    sb_n.push_back(e);
  endtask

  task automatic applyStimulusWide(input logic [15:0] a, input logic [7:0] b);
    result_t e;
    int guard = 0;
    while (!w_in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!w_in_ready) begin
      checks++; failures++;
      $display("[TB] FAIL accept_timeout_w in_ready=%0b required=1", w_in_ready);
    end
    w_in_valid = 1'b1;
    w_numer    = a;
    w_denom    = b;
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    w_numer    = 16'($urandom);
    w_denom    = 8'($urandom);
    e.q = (b == 8'd0) ? 16'hFFFF : a / b;
    e.r = (b == 8'd0) ? a[7:0] : 8'(a % b);
    e.z = (b == 8'd0);
    sb_w.push_back(e);
  endtask

  // Counts edges after the accept edge until out_valid rises (bounded).
  // Also records whether in_ready was ever seen high while waiting.
  task automatic wait_out_n(output int edges, output logic saw_ready);
    edges = 0;
    saw_ready = 1'b0;
    while (!n_out_valid && edges < 100) begin
      if (n_in_ready) saw_ready = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    if (n_in_ready) saw_ready = 1'b1;
  endtask

  task automatic wait_out_w(output int edges);
    edges = 0;
    while (!w_out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    n_in_valid = 1'b0; n_numer = '0; n_denom = '0; n_out_ready = 1'b1;
    w_in_valid = 1'b0; w_numer = '0; w_denom = '0; w_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({n_in_ready, n_out_valid, n_quot, n_rem, n_dbz} !== {1'b1, 1'b0, 8'd0, 4'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_n got rdy=%0b vld=%0b q=%0d r=%0d z=%0b required rdy=1 vld=0 q=0 r=0 z=0",
               n_in_ready, n_out_valid, n_quot, n_rem, n_dbz);
    end
    checks++;
    if ({w_in_ready, w_out_valid, w_quot, w_rem, w_dbz} !== {1'b1, 1'b0, 16'd0, 8'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_w got rdy=%0b vld=%0b q=%0d r=%0d z=%0b required rdy=1 vld=0 q=0 r=0 z=0",
               w_in_ready, w_out_valid, w_quot, w_rem, w_dbz);
    end
  endtask

  // Runs one narrow operation to completion with out_ready high. Checks
  // latency, in_ready, the result and the return to idle after the handshake.
  task automatic test_op(input string name, input logic [7:0] a, input logic [3:0] b);
    int      edges;
    logic    saw_ready;
    result_t e;
    int      lat_exp;
    n_out_ready = 1'b1;
    lat_exp = (b == 4'd0) ? 0 : 8;
    applyStimulus(a, b);
    wait_out_n(edges, saw_ready);
    checks++;
    if (edges !== lat_exp || !n_out_valid) begin
      failures++;
      $display("[TB] FAIL %s_latency got=%0d required=%0d", name, edges, lat_exp);
    end
    checks++;
    if (saw_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_in_ready_busy got=1 required=0", name);
    end
    if (sb_n.size() == 0) begin
      checks++; failures++;
      $display("[TB] FAIL %s_scoreboard got=empty required=entry", name);
    end else begin
      e = sb_n.pop_front();
      checks++;
      if ({8'd0, n_quot, 4'd0, n_rem, n_dbz} !== e) begin
        failures++;
        $display("[TB] FAIL %s_result got q=%0d r=%0d z=%0b required q=%0d r=%0d z=%0b",
                 name, n_quot, n_rem, n_dbz, e.q, e.r, e.z);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({n_out_valid, n_in_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL %s_after_handshake got vld=%0b rdy=%0b required vld=0 rdy=1",
               name, n_out_valid, n_in_ready);
    end
  endtask

  task automatic test_basic();
    test_op("div_100_5", 8'd100, 4'd5);
  endtask

  task automatic test_back_to_back();
    test_op("div_200_4", 8'd200, 4'd4);
    test_op("div_255_7", 8'd255, 4'd7);
    test_op("div_255_1", 8'd255, 4'd1);
    test_op("div_0_15", 8'd0, 4'd15);
    test_op("div_3_15", 8'd3, 4'd15);
  endtask

  task automatic test_div_by_zero();
    test_op("div_13_0", 8'd13, 4'd0);
    test_op("div_9_3", 8'd9, 4'd3);
  endtask

  task automatic test_backpressure();
    int      edges;
    logic    saw_ready;
    result_t e;
    n_out_ready = 1'b0;
    applyStimulus(8'd77, 4'd9);
    wait_out_n(edges, saw_ready);
    checks++;
    if (edges !== 8 || !n_out_valid) begin
      failures++;
      $display("[TB] FAIL bp_latency got=%0d required=8", edges);
    end
    e = sb_n.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({n_out_valid, n_in_ready, 8'd0, n_quot, 4'd0, n_rem, n_dbz} !== {1'b1, 1'b0, e}) begin
        failures++;
        $display("[TB] FAIL bp_hold_%0d got vld=%0b rdy=%0b q=%0d r=%0d z=%0b required vld=1 rdy=0 q=%0d r=%0d z=%0b",
                 i, n_out_valid, n_in_ready, n_quot, n_rem, n_dbz, e.q, e.r, e.z);
      end
      @(posedge clk); #1;
    end
    n_out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({n_out_valid, n_in_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL bp_release got vld=%0b rdy=%0b required vld=0 rdy=1", n_out_valid, n_in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (n_out_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp_single_consume_%0d got vld=%0b required vld=0", i, n_out_valid);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic seen_valid;
    n_out_ready = 1'b1;
    applyStimulus(8'd100, 4'd5);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb_n.pop_back());
    checks++;
    if ({n_in_ready, n_out_valid, n_quot, n_rem, n_dbz} !== {1'b1, 1'b0, 8'd0, 4'd0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL midop_reset got rdy=%0b vld=%0b q=%0d r=%0d z=%0b required rdy=1 vld=0 q=0 r=0 z=0",
               n_in_ready, n_out_valid, n_quot, n_rem, n_dbz);
    end
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (n_out_valid) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midop_stale_result got vld=1 required vld=0");
    end
    test_op("div_after_reset_100_5", 8'd100, 4'd5);
  endtask

  task automatic test_wide();
    logic [15:0] na[3] = '{16'd65535, 16'd0, 16'd65535};
    logic [7:0]  da[3] = '{8'd1, 8'd255, 8'd255};
    logic [15:0] a;
    logic [7:0]  b;
    int          edges;
    int          lat_exp;
    result_t     e;
    w_out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i < 3) begin
        a = na[i];
        b = da[i];
      end else begin
        a = 16'($urandom);
        b = (i % 10 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      end
      lat_exp = (b == 8'd0) ? 0 : 16;
      applyStimulusWide(a, b);
      wait_out_w(edges);
      checks++;
      if (edges !== lat_exp || !w_out_valid) begin
        failures++;
        $display("[TB] FAIL wide_latency_%0d (%0d/%0d) got=%0d required=%0d", i, a, b, edges, lat_exp);
      end
      if (sb_w.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL wide_scoreboard_%0d got=empty required=entry", i);
      end else begin
        e = sb_w.pop_front();
        checks++;
        if ({w_quot, w_rem, w_dbz} !== e) begin
          failures++;
          $display("[TB] FAIL wide_result_%0d (%0d/%0d) got q=%0d r=%0d z=%0b required q=%0d r=%0d z=%0b",
                   i, a, b, w_quot, w_rem, w_dbz, e.q, e.r, e.z);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_by_zero();
    test_backpressure();
    test_reset_midop();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout required=completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
